// File: rtl/sysarr_pkg.sv
// Shared types and constants for the systolic-array operand feeder.
package sysarr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int WORD_W      = 32;
  localparam int DEF_N       = 4;
  localparam int DEF_RUN_LEN = 20;
  localparam int FLG_W       = 7;

endpackage

// File: rtl/sysarr_opbuf.sv
// n-slot operand beat bank: indexed write, indexed read with zero-fill past slot n-1.
module sysarr_opbuf
  import sysarr_pkg::*;
#(
  parameter int N = WORD_W - 1,
  parameter int n = DEF_N
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [FLG_W-1:0]     widx,
  input  logic [(N+1)*n-1:0]   wdata,
  input  logic [FLG_W-1:0]     ridx,
  output logic [(N+1)*n-1:0]   rdata
);

  localparam int BW = (N + 1) * n;
  localparam int IW = (n > 1) ? $clog2(n) : 1;

  logic [BW-1:0] mem [n];

  // Operand storage is data-only; it carries no reset.
  always_ff @(posedge clk) begin
    if (we && ({1'b0, widx} < 8'(n)))
      mem[widx[IW-1:0]] <= wdata;
  end

  always_comb begin
    rdata = '0;
    if ({1'b0, ridx} < 8'(n))
      rdata = mem[ridx[IW-1:0]];
  end

endmodule

// File: rtl/sysarr_feeder.sv
// Collects n operand beats for A and B, then streams RUN_LEN indexed beats
// (loaded data followed by zero padding) into the systolic array.
module sysarr_feeder
  import sysarr_pkg::*;
#(
  parameter int N       = WORD_W - 1,
  parameter int n       = DEF_N,
  parameter int RUN_LEN = DEF_RUN_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [(N+1)*n-1:0]   in_a,
  input  logic [(N+1)*n-1:0]   in_b,
  input  logic                 stall,
  output logic [(N+1)*n-1:0]   arr1,
  output logic [(N+1)*n-1:0]   arr2,
  output logic [FLG_W-1:0]     flg,
  output logic                 out_valid,
  output logic                 done
);

  localparam int BW = (N + 1) * n;
  localparam int IW = (n > 1) ? $clog2(n) : 1;
  localparam logic [IW-1:0]    LAST_SLOT = IW'(n - 1);
  localparam logic [FLG_W-1:0] LAST_BEAT = FLG_W'(RUN_LEN - 1);

  state_t           state;
  logic [IW-1:0]    lcnt;
  logic             accept;
  logic             last_load;
  logic [FLG_W-1:0] ridx;
  logic [BW-1:0]    rd_a, rd_b;
  logic [BW-1:0]    first_a, first_b;

  assign in_ready  = (state != RUN);
  assign accept    = in_valid && in_ready && !clr;
  assign last_load = accept && (lcnt == LAST_SLOT);

  // Read one beat ahead while running; slot 0 is fetched when the load completes.
  assign ridx = (state == RUN) ? flg + FLG_W'(1) : '0;

  // With a single slot the first beat is still being written, so bypass it.
  assign first_a = (n == 1) ? in_a : rd_a;
  assign first_b = (n == 1) ? in_b : rd_b;

  sysarr_opbuf #(.N(N), .n(n)) u_buf_a (
    .clk   (clk),
    .we    (accept),
    .widx  (FLG_W'(lcnt)),
    .wdata (in_a),
    .ridx  (ridx),
    .rdata (rd_a)
  );

  sysarr_opbuf #(.N(N), .n(n)) u_buf_b (
    .clk   (clk),
    .we    (accept),
    .widx  (FLG_W'(lcnt)),
    .wdata (in_b),
    .ridx  (ridx),
    .rdata (rd_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lcnt      <= '0;
      flg       <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      arr1      <= '0;
      arr2      <= '0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        state     <= IDLE;
        lcnt      <= '0;
        flg       <= '0;
        out_valid <= 1'b0;
        arr1      <= '0;
        arr2      <= '0;
      end else begin
        case (state)
          IDLE, LOAD: begin
            if (accept) begin
              if (last_load) begin
                state     <= RUN;
                lcnt      <= '0;
                flg       <= '0;
                out_valid <= 1'b1;
                arr1      <= first_a;
                arr2      <= first_b;
              end else begin
                state <= LOAD;
                lcnt  <= lcnt + IW'(1);
              end
            end
          end
          RUN: begin
            if (!stall) begin
              if (flg == LAST_BEAT) begin
                state     <= IDLE;
                flg       <= '0;
                out_valid <= 1'b0;
                arr1      <= '0;
                arr2      <= '0;
                done      <= 1'b1;
              end else begin
                flg  <= flg + FLG_W'(1);
                arr1 <= rd_a;
                arr2 <= rd_b;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sysarr_feeder.sv
// Randomized scenario bench for sysarr_feeder against a slot/zero-fill reference model.
module tb_sysarr_feeder;
  import sysarr_pkg::*;

  localparam int NN = 4;
  localparam int RL = 20;
  localparam int BW = 32 * NN;

  logic             clk = 1'b0;
  logic             rst, clr, in_valid, stall;
  logic [BW-1:0]    in_a, in_b, arr1, arr2;
  logic [FLG_W-1:0] flg;
  logic             in_ready, out_valid, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BW-1:0] exp_a [NN];
  logic [BW-1:0] exp_b [NN];

  always #5 clk = ~clk;

  sysarr_feeder #(.N(31), .n(NN), .RUN_LEN(RL)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .stall     (stall),
    .arr1      (arr1),
    .arr2      (arr2),
    .flg       (flg),
    .out_valid (out_valid),
    .done      (done)
  );

  // Beat k of a run: loaded slot k, zero once the loaded slots are exhausted.
  function automatic logic [BW-1:0] model(input bit col, input int k);
    if (k >= NN) return '0;
    return col ? exp_b[k] : exp_a[k];
  endfunction

  function automatic logic [BW-1:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic randomize_set();
    for (int i = 0; i < NN; i++) begin
      exp_a[i] = rnd_beat();
      exp_b[i] = rnd_beat();
    end
  endtask

  task automatic load_set(input int gap);
    for (int i = 0; i < NN; i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_a = rnd_beat();
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL load_gap beat %0d: in_ready=%b required 1", i, in_ready);
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_a = exp_a[i];
      in_b = exp_b[i];
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL load beat %0d: in_ready=%b out_valid=%b required 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic run_check(input string tag, input int stall_at, input int stall_len, input bit hold_valid);
    int k = 0;
    int held = 0;
    for (int c = 0; c < RL + stall_len + 2 && k < RL; c++) begin
      @(negedge clk);
      in_valid = hold_valid;
      if (hold_valid) begin
        in_a = rnd_beat();
        in_b = rnd_beat();
      end
      n_checks++;
      if (out_valid !== 1'b1 || flg !== FLG_W'(k) || arr1 !== model(0, k) || arr2 !== model(1, k)) begin
        n_fail++;
        $display("FAIL %s beat %0d: vld=%b flg=%0d arr1=%h arr2=%h required vld=1 flg=%0d arr1=%h arr2=%h",
                 tag, k, out_valid, flg, arr1, arr2, k, model(0, k), model(1, k));
      end
      n_checks++;
      if (done !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s run_ctl beat %0d: done=%b in_ready=%b required 0/0", tag, k, done, in_ready);
      end
      if (k == stall_at && held < stall_len) begin
        stall = 1'b1;
        held++;
      end else begin
        stall = 1'b0;
        k++;
      end
    end
    n_checks++;
    if (k != RL) begin
      n_fail++;
      $display("FAIL %s run_length: reached %0d beats required %0d", tag, k, RL);
    end
    @(negedge clk);
    stall = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || flg !== '0 || arr1 !== '0 || arr2 !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s end: done=%b vld=%b flg=%0d arr1=%h arr2=%h rdy=%b required 1/0/0/0/0/1",
               tag, done, out_valid, flg, arr1, arr2, in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse: done=%b vld=%b required 0/0", tag, done, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; stall = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || flg !== '0 || arr1 !== '0 || arr2 !== '0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: vld=%b flg=%0d arr1=%h arr2=%h done=%b required all 0",
               out_valid, flg, arr1, arr2, done);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b vld=%b done=%b required 1/0/0", in_ready, out_valid, done);
    end
  endtask

  task automatic test_basic();
    exp_a[0] = {32'h3FC00000, 32'h3E800000, 32'h40700000, 32'h3E000000};
    exp_b[0] = {32'h3E800000, 32'h3DCCCCCD, 32'h3E99999A, 32'h3E4CCCCD};
    for (int i = 1; i < NN; i++) begin
      exp_a[i] = rnd_beat();
      exp_b[i] = rnd_beat();
    end
    load_set(0);
    run_check("basic", -1, 0, 1'b0);
  endtask

  task automatic test_gaps();
    load_set(2);
    run_check("gaps", -1, 0, 1'b0);
  endtask

  task automatic test_stall();
    randomize_set();
    load_set(0);
    run_check("stall", 2, 3, 1'b0);
  endtask

  task automatic test_hold_valid();
    randomize_set();
    load_set(1);
    run_check("hold_valid", -1, 0, 1'b1);
  endtask

  task automatic test_clr();
    randomize_set();
    load_set(0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (flg !== FLG_W'(c) || out_valid !== 1'b1 || arr1 !== model(0, c)) begin
        n_fail++;
        $display("FAIL clr_prerun beat %0d: flg=%0d vld=%b arr1=%h required flg=%0d vld=1 arr1=%h",
                 c, flg, out_valid, arr1, c, model(0, c));
      end
    end
    clr = 1'b1;
    @(negedge clk);
    // clr stays high one more cycle in IDLE together with a junk beat that must not land.
    in_valid = 1'b1;
    in_a = rnd_beat();
    in_b = rnd_beat();
    n_checks++;
    if (out_valid !== 1'b0 || flg !== '0 || arr1 !== '0 || arr2 !== '0 || done !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_flush: vld=%b flg=%0d arr1=%h arr2=%h done=%b rdy=%b required 0/0/0/0/0/1",
               out_valid, flg, arr1, arr2, done, in_ready);
    end
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_nodone: done=%b vld=%b required 0/0", done, out_valid);
    end
    randomize_set();
    load_set(0);
    run_check("after_clr", -1, 0, 1'b0);
  endtask

  task automatic test_rst_async();
    // Partial load of two beats, then an asynchronous reset.
    randomize_set();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a = exp_a[i];
      in_b = exp_b[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || flg !== '0 || arr1 !== '0 || done !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_midload: vld=%b flg=%0d arr1=%h done=%b rdy=%b required 0/0/0/0/1",
               out_valid, flg, arr1, done, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    randomize_set();
    load_set(0);
    run_check("after_rst_load", -1, 0, 1'b0);

    // Reset in the middle of a run must clear outputs without waiting for a clock.
    randomize_set();
    load_set(0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    n_checks++;
    if (flg !== FLG_W'(3) || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_prerun: flg=%0d vld=%b required 3/1", flg, out_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || flg !== '0 || arr1 !== '0 || arr2 !== '0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_midrun: vld=%b flg=%0d arr1=%h arr2=%h done=%b required all 0",
               out_valid, flg, arr1, arr2, done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_nodone: done=%b rdy=%b required 0/1", done, in_ready);
    end
    randomize_set();
    load_set(0);
    run_check("after_rst_run", -1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_stall();
    test_hold_valid();
    test_clr();
    test_rst_async();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sysarr_feeder.md
SYSARR_FEEDER -- requirements
Module: sysarr_feeder

Interface
REQ-001 Parameter N, default 31, MSB index of one IEEE-754 single word (word width N+1).
REQ-002 Parameter n, default 4, array dimension (lanes and beats per operand set).
REQ-003 Parameter RUN_LEN, default 20, beats per run; legal range n..128.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 clr  input  1  synchronous flush to IDLE.
REQ-007 in_valid  input  1  load beat offered.
REQ-008 in_ready  output  1  load beat accepted when in_valid&in_ready.
REQ-009 in_a  input  (N+1)*n  row operand beat, lane i at bits [(N+1)*i +: N+1].
REQ-010 in_b  input  (N+1)*n  column operand beat, same packing.
REQ-011 stall  input  1  freeze streaming.
REQ-012 arr1  output  (N+1)*n  registered row operands to sysarray1.
REQ-013 arr2  output  (N+1)*n  registered column operands to sysarray1.
REQ-014 flg  output  7  registered beat index to sysarray1.
REQ-015 out_valid  output  1  arr1/arr2/flg carry a run beat.
REQ-016 done  output  1  one-cycle pulse after final run beat.

Function
REQ-017 States SHALL be IDLE, LOAD, RUN; in_ready SHALL be 1 in IDLE and LOAD, 0 in RUN.
REQ-018 IDLE: accepted beat SHALL be stored at buffer slot 0 and move state to LOAD (to RUN if n=1).
REQ-019 LOAD: each accepted beat SHALL be stored at next slot (load counter 0..n-1); beat n-1 accepted moves to RUN.
REQ-020 in_valid low in LOAD SHALL hold the load counter; no timeout.
REQ-021 First RUN beat SHALL appear on outputs the cycle after beat n-1 is accepted, with flg=0, out_valid=1.
REQ-022 RUN beat k (flg=k): arr1/arr2 = buffer slot k for k<n, all-zero for n<=k<RUN_LEN.
REQ-023 flg SHALL advance by 1 per non-stalled RUN cycle; stall=1 holds arr1, arr2, flg, out_valid unchanged.
REQ-024 After beat RUN_LEN-1 is presented one non-stalled cycle, next cycle: out_valid=0, flg=0, arr1=arr2=0, done=1, state IDLE.
REQ-025 done SHALL be 1 for exactly one cycle per completed run, never after clr or rst.
REQ-026 stall SHALL be ignored outside RUN.
REQ-027 clr SHALL override all other inputs: next cycle state IDLE, load counter 0, flg 0, out_valid 0, arr1=arr2=0, done 0; buffer contents need not clear.
REQ-028 in_valid with clr in same cycle SHALL not store the beat.
REQ-029 Data words SHALL pass bit-exact; no arithmetic on operands.
REQ-030 Outside RUN arr1, arr2, flg SHALL be 0.

Reset
REQ-031 rst high SHALL immediately force state IDLE, load counter 0, flg 0, arr1 0, arr2 0, out_valid 0, done 0, in_ready 1 after release.
REQ-032 rst asserted mid-LOAD or mid-RUN SHALL discard the partial operation; first post-reset accepted beat is slot 0.
REQ-033 Operand buffer SHALL NOT require reset.

Structure
REQ-034 Package sysarr_pkg SHALL hold state enum (IDLE, LOAD, RUN), word width constant, default n and RUN_LEN, flg width 7.
REQ-035 Sub-module sysarr_opbuf (n-slot, (N+1)*n-wide write-indexed register bank with read-index mux and zero-fill beyond n) SHALL be instantiated twice, for A and B.
REQ-036 Control FSM and counters SHALL reside in sysarr_feeder.

Verification
REQ-037 Load beats A={0x3E000000,0x40700000,0x3E800000,0x3FC00000}, B={0x3E4CCCCD,0x3E99999A,0x3DCCCCCD,0x3E800000} then three more, in_valid continuous -> out_valid rises next cycle after 4th beat, flg 0..19, beats 0..3 equal loaded words bit-exact, beats 4..19 zero, done pulse once.
REQ-038 in_valid gaps of 2 cycles between load beats -> identical output stream to REQ-037, in_ready stays 1 through LOAD.
REQ-039 stall high 3 cycles at flg=2 -> flg, arr1, arr2 held 3 cycles, run extends by 3, done still single pulse.
REQ-040 clr at flg=5 -> next cycle out_valid 0, flg 0, no done; new load of 4 beats restarts at flg 0.
REQ-041 rst asserted asynchronously mid-LOAD after 2 beats -> outputs zero immediately; 4 fresh beats produce run with only fresh data.
REQ-042 in_valid held high in RUN -> in_ready 0, no beats consumed, buffer unchanged.
